alu_writeback: RTL and testbench

ALU_WRITEBACK -- requirements
Module: alu_writeback

---
 rtl/alu_writeback.sv | 98 +++++++++
 tb/tb_alu_writeback.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/alu_writeback.sv
// alu_writeback: FIFO of completed ALU ops retiring to the register file and architectural flags.
module alu_writeback #(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [31:0]                  in_result,
  input  logic [5:0]                   in_status,
  input  logic [2:0]                   in_dest,
  input  logic                         in_wr_reg,
  input  logic                         in_wr_flags,
  input  logic                         flush,
  input  logic                         rf_busy,
  output logic                         rf_wr_en,
  output logic [2:0]                   rf_wr_idx,
  output logic [31:0]                  rf_wr_data,
  output logic [5:0]                   flags,
  output logic [5:0]                   flags_fwd,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy,
  output logic [15:0]                  retire_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int OW = $clog2(DEPTH+1);
  typedef struct packed {
    logic [31:0] result;
    logic [5:0]  status;
    logic [2:0]  dest;
    logic        wr_reg;
    logic        wr_flags;
  } entry_t;
  entry_t          mem_q [DEPTH];
  entry_t          mem_d [DEPTH];
  entry_t          head;
  logic [AW-1:0]   rd_q, rd_d, wr_q, wr_d;
  logic [OW-1:0]   occ_q, occ_d;
  logic [5:0]      flags_q, flags_d;
  logic [15:0]     cnt_q, cnt_d;
  logic            push, retire, nonempty;
  assign head         = mem_q[rd_q];
  assign nonempty     = occ_q != '0;
  assign in_ready     = occ_q < OW'(DEPTH);
  assign push         = in_valid & in_ready & ~flush;
  assign retire       = nonempty & ~rf_busy & ~flush;
  assign rf_wr_en     = retire & head.wr_reg;
  assign rf_wr_idx    = nonempty ? head.dest : '0;
  assign rf_wr_data   = nonempty ? head.result : '0;
  assign flags        = flags_q;
  assign occupancy    = occ_q;
  assign retire_count = cnt_q;
  always_comb begin
    mem_d   = mem_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    occ_d   = occ_q;
    flags_d = flags_q;
    cnt_d   = cnt_q;
    if (flush) begin
      rd_d  = wr_q;
      occ_d = '0;
    end else begin
      if (push) begin
        mem_d[wr_q] = '{in_result, in_status, in_dest, in_wr_reg, in_wr_flags};
        wr_d        = wr_q + 1'b1;
      end
      if (retire) begin
        rd_d    = rd_q + 1'b1;
        cnt_d   = cnt_q + 16'd1;
        flags_d = head.wr_flags ? head.status : flags_q;
      end
      occ_d = occ_q + OW'(push) - OW'(retire);
    end
  end
  // later matches overwrite earlier ones, so the youngest flag-writer wins
  always_comb begin
    flags_fwd = flags_q;
    for (int i = 0; i < DEPTH; i++)
      flags_fwd = (OW'(i) < occ_q && mem_q[rd_q + AW'(i)].wr_flags) ? mem_q[rd_q + AW'(i)].status : flags_fwd;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q   <= '{default: '0};
      rd_q    <= '0;
      wr_q    <= '0;
      occ_q   <= '0;
      flags_q <= '0;
      cnt_q   <= '0;
    end else begin
      mem_q   <= mem_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      occ_q   <= occ_d;
      flags_q <= flags_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: tb/tb_alu_writeback.sv
// tb_alu_writeback: directed vector table, random run against a queue model, reset and counter-wrap cases.
module tb_alu_writeback;
  localparam int DEPTH = 2;
  localparam int OW = $clog2(DEPTH+1);
  logic clk = 1'b0, rst_n = 1'b0;
  logic in_valid = 1'b0, in_ready, in_wr_reg = 1'b0, in_wr_flags = 1'b0, flush = 1'b0, rf_busy = 1'b0, rf_wr_en;
  logic [31:0] in_result = '0, rf_wr_data;
  logic [5:0] in_status = '0, flags, flags_fwd;
  logic [2:0] in_dest = '0, rf_wr_idx;
  logic [OW-1:0] occupancy;
  logic [15:0] retire_count;
  int checks = 0, failures = 0;
  alu_writeback #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_status(in_status), .in_dest(in_dest),
    .in_wr_reg(in_wr_reg), .in_wr_flags(in_wr_flags), .flush(flush), .rf_busy(rf_busy),
    .rf_wr_en(rf_wr_en), .rf_wr_idx(rf_wr_idx), .rf_wr_data(rf_wr_data),
    .flags(flags), .flags_fwd(flags_fwd), .occupancy(occupancy), .retire_count(retire_count)
  );
  always #5 clk = ~clk;
  typedef struct packed {
    logic [31:0] res;
    logic [5:0]  st;
    logic [2:0]  dst;
    logic        wr;
    logic        wf;
  } ent_t;
  typedef struct packed {
    logic        v;
    logic [31:0] res;
    logic [5:0]  st;
    logic [2:0]  dst;
    logic        wr, wf, fl, bz;
    logic        e_en;
    logic [2:0]  e_idx;
    logic [31:0] e_data;
    logic [1:0]  e_occ;
    logic        e_rdy;
    logic [5:0]  e_flags, e_fwd;
    logic [15:0] e_cnt;
  } vec_t;
  ent_t mq[$];
  logic [5:0] m_flags = '0;
  logic [15:0] m_cnt = '0;
  vec_t tbl[18];
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", n, a, e, $time);
    end
  endtask
  task automatic apply(input logic v, input logic [31:0] r, input logic [5:0] s, input logic [2:0] d,
                       input logic wr, input logic wf, input logic fl, input logic bz);
    in_valid = v; in_result = r; in_status = s; in_dest = d;
    in_wr_reg = wr; in_wr_flags = wf; flush = fl; rf_busy = bz;
  endtask
  task automatic model_reset();
    mq.delete();
    m_flags = '0;
    m_cnt = '0;
  endtask
  task automatic model_check();
    logic [5:0] f;
    logic busy_head;
    f = m_flags;
    foreach (mq[i]) if (mq[i].wf) f = mq[i].st;
    busy_head = mq.size() > 0;
    chk("occupancy", 32'(occupancy), 32'(mq.size()));
    chk("in_ready", 32'(in_ready), 32'(mq.size() < DEPTH));
    chk("rf_wr_en", 32'(rf_wr_en), 32'(busy_head && !rf_busy && !flush && mq[0].wr));
    chk("rf_wr_idx", 32'(rf_wr_idx), busy_head ? 32'(mq[0].dst) : 32'd0);
    chk("rf_wr_data", rf_wr_data, busy_head ? mq[0].res : 32'd0);
    chk("flags", 32'(flags), 32'(m_flags));
    chk("flags_fwd", 32'(flags_fwd), 32'(f));
    chk("retire_count", 32'(retire_count), 32'(m_cnt));
  endtask
  task automatic step();
    logic ret, psh;
    if (flush) mq.delete();
    else begin
      ret = mq.size() > 0 && !rf_busy;
      psh = in_valid && mq.size() < DEPTH;
      if (ret) begin
        if (mq[0].wf) m_flags = mq[0].st;
        m_cnt++;
        void'(mq.pop_front());
      end
      if (psh) mq.push_back('{in_result, in_status, in_dest, in_wr_reg, in_wr_flags});
    end
    @(posedge clk);
    #1;
  endtask
  task automatic rand_apply(input logic bz_en);
    apply($urandom_range(0, 3) != 0, $urandom, 6'($urandom), 3'($urandom), 1'($urandom), 1'($urandom),
          $urandom_range(0, 15) == 0, bz_en && $urandom_range(0, 2) == 0);
  endtask
  initial begin
    //          v  res            st     dst   wr    wf    fl    bz    en    idx   data           occ   rdy   flags  fwd    cnt
    tbl[0]  = '{1'b1, 32'hDEADBEEF, 6'h01, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0,        2'd0, 1'b1, 6'h00, 6'h00, 16'd0};
    tbl[1]  = '{1'b0, 32'h0,        6'h00, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd3, 32'hDEADBEEF, 2'd1, 1'b1, 6'h00, 6'h01, 16'd0};
    tbl[2]  = '{1'b1, 32'h11111111, 6'h02, 3'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 32'h0,        2'd0, 1'b1, 6'h01, 6'h01, 16'd1};
    tbl[3]  = '{1'b1, 32'h22222222, 6'h08, 3'd2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'd1, 32'h11111111, 2'd1, 1'b1, 6'h01, 6'h01, 16'd1};
    tbl[4]  = '{1'b1, 32'h33333333, 6'h10, 3'd5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd1, 32'h11111111, 2'd2, 1'b0, 6'h01, 6'h08, 16'd1};
    tbl[5]  = '{1'b1, 32'h33333333, 6'h10, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 32'h11111111, 2'd2, 1'b0, 6'h01, 6'h08, 16'd1};
    tbl[6]  = '{1'b1, 32'h33333333, 6'h10, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd2, 32'h22222222, 2'd1, 1'b1, 6'h01, 6'h08, 16'd2};
    tbl[7]  = '{1'b0, 32'h0,        6'h00, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd5, 32'h33333333, 2'd1, 1'b1, 6'h08, 6'h08, 16'd3};
    tbl[8]  = '{1'b1, 32'hAAAA0000, 6'h04, 3'd6, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 32'h0,        2'd0, 1'b1, 6'h08, 6'h08, 16'd4};
    tbl[9]  = '{1'b1, 32'hBBBB0000, 6'h3F, 3'd7, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd6, 32'hAAAA0000, 2'd1, 1'b1, 6'h08, 6'h04, 16'd4};
    tbl[10] = '{1'b0, 32'h0,        6'h00, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd6, 32'hAAAA0000, 2'd2, 1'b0, 6'h08, 6'h04, 16'd4};
    tbl[11] = '{1'b0, 32'h0,        6'h00, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd7, 32'hBBBB0000, 2'd1, 1'b1, 6'h04, 6'h04, 16'd5};
    tbl[12] = '{1'b1, 32'hCCCC0001, 6'h20, 3'd1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 32'h0,        2'd0, 1'b1, 6'h04, 6'h04, 16'd6};
    tbl[13] = '{1'b1, 32'hDDDD0002, 6'h01, 3'd2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'd1, 32'hCCCC0001, 2'd1, 1'b1, 6'h04, 6'h20, 16'd6};
    tbl[14] = '{1'b1, 32'hEEEE0003, 6'h3F, 3'd4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd1, 32'hCCCC0001, 2'd2, 1'b0, 6'h04, 6'h01, 16'd6};
    tbl[15] = '{1'b0, 32'h0,        6'h00, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0,        2'd0, 1'b1, 6'h04, 6'h04, 16'd6};
    tbl[16] = '{1'b1, 32'hEEEE0003, 6'h3F, 3'd4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 32'h0,        2'd0, 1'b1, 6'h04, 6'h04, 16'd6};
    tbl[17] = '{1'b0, 32'h0,        6'h00, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0,        2'd0, 1'b1, 6'h04, 6'h04, 16'd6};
    #12;
    model_check();
    @(negedge clk);
    rst_n = 1'b1;
    foreach (tbl[i]) begin
      apply(tbl[i].v, tbl[i].res, tbl[i].st, tbl[i].dst, tbl[i].wr, tbl[i].wf, tbl[i].fl, tbl[i].bz);
      #1;
      chk($sformatf("t%0d_en", i), 32'(rf_wr_en), 32'(tbl[i].e_en));
      chk($sformatf("t%0d_idx", i), 32'(rf_wr_idx), 32'(tbl[i].e_idx));
      chk($sformatf("t%0d_data", i), rf_wr_data, tbl[i].e_data);
      chk($sformatf("t%0d_occ", i), 32'(occupancy), 32'(tbl[i].e_occ));
      chk($sformatf("t%0d_rdy", i), 32'(in_ready), 32'(tbl[i].e_rdy));
      chk($sformatf("t%0d_flags", i), 32'(flags), 32'(tbl[i].e_flags));
      chk($sformatf("t%0d_fwd", i), 32'(flags_fwd), 32'(tbl[i].e_fwd));
      chk($sformatf("t%0d_cnt", i), 32'(retire_count), 32'(tbl[i].e_cnt));
      step();
    end
    for (int n = 0; n < 3000; n++) begin
      rand_apply(1'b1);
      #1;
      model_check();
      step();
    end
    apply(1'b0, 32'h0, 6'h00, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    #1; model_check(); step();
    apply(1'b1, 32'h12345678, 6'h2A, 3'd4, 1'b1, 1'b1, 1'b0, 1'b0);
    #1; model_check(); step();
    apply(1'b0, 32'h0, 6'h00, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1; model_check(); step();
    apply(1'b1, 32'h0000AAAA, 6'h11, 3'd1, 1'b1, 1'b1, 1'b0, 1'b1);
    #1; model_check(); step();
    apply(1'b1, 32'h0000BBBB, 6'h22, 3'd2, 1'b1, 1'b1, 1'b0, 1'b1);
    #1; model_check(); step();
    apply(1'b0, 32'h0, 6'h00, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1; model_check();
    rst_n = 1'b0;
    #1;
    chk("arst_occ", 32'(occupancy), 32'd0);
    chk("arst_flags", 32'(flags), 32'd0);
    chk("arst_en", 32'(rf_wr_en), 32'd0);
    chk("arst_rdy", 32'(in_ready), 32'd1);
    chk("arst_fwd", 32'(flags_fwd), 32'd0);
    chk("arst_data", rf_wr_data, 32'd0);
    chk("arst_cnt", 32'(retire_count), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 65536; n++) begin
      apply(1'b1, $urandom, 6'($urandom), 3'($urandom), 1'($urandom), 1'($urandom), 1'b0, 1'b0);
      #1;
      model_check();
      step();
    end
    apply(1'b0, 32'h0, 6'h00, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("cnt_ffff", 32'(retire_count), 32'h0000FFFF);
    model_check();
    step();
    chk("cnt_wrap", 32'(retire_count), 32'd0);
    chk("cnt_wrap_occ", 32'(occupancy), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
